// File: rtl/axi_apb_pkg.sv
// -----------------------------------------------------------------------------
// axi_apb_pkg
// Shared types and constants for the AXI3-to-APB4 responder bridge:
//   state_e    - bridge FSM states
//   RESP_*     - AXI response codes driven on bresp/rresp
//   BURST_*    - AXI burst encodings (only FIXED is special-cased)
//   next_addr  - per-beat address step (FIXED holds, everything else +4)
// -----------------------------------------------------------------------------
package axi_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RSETUP  = 3'd1,
      ST_RACCESS = 3'd2,
      ST_RDATA   = 3'd3,
      ST_WDATA   = 3'd4,
      ST_WSETUP  = 3'd5,
      ST_WACCESS = 3'd6,
      ST_BRESP   = 3'd7
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   // Beats are always 4 bytes wide regardless of AxSIZE; WRAP and the reserved
   // encoding are deliberately treated like INCR (no wrap boundary, no 4KB check).
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
      logic [31:0] res;
      if (burst == BURST_FIXED) begin
         res = addr;
      end else begin
         res = addr + 32'd4;
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_apb_slave_bridge.sv
// -----------------------------------------------------------------------------
// axi_apb_slave_bridge
// AXI3 responder (32-bit data, one transaction in flight) that turns every AXI
// beat of an INCR/FIXED burst into one APB4 SETUP+ACCESS transfer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   aw*_i / awvalid_i / awready_o   write address channel
//   w*_i  / wvalid_i  / wready_o    write data channel (wid_i ignored)
//   bid_o, bresp_o, bvalid_o / bready_i   write response channel
//   ar*_i / arvalid_i / arready_o   read address channel
//   rid_o, rdata_o, rresp_o, rlast_o, rvalid_o / rready_i   read data channel
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o   APB requester
//   prdata_i, pready_i, pslverr_i                             APB completer
// Parameters:
//   ID_WIDTH     AXI ID width
//   TIMEOUT_CYC  ACCESS cycles tolerated without pready before a forced
//                SLVERR (0 disables the timeout)
// -----------------------------------------------------------------------------
module axi_apb_slave_bridge
   import axi_apb_pkg::*;
#(
   parameter int ID_WIDTH    = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ID_WIDTH-1:0] awid_i,
   input  logic [31:0]         awaddr_i,
   input  logic [3:0]          awlen_i,
   input  logic [2:0]          awsize_i,
   input  logic [1:0]          awburst_i,
   input  logic                awvalid_i,
   output logic                awready_o,
   input  logic [ID_WIDTH-1:0] wid_i,
   input  logic [31:0]         wdata_i,
   input  logic [3:0]          wstrb_i,
   input  logic                wlast_i,
   input  logic                wvalid_i,
   output logic                wready_o,
   output logic [ID_WIDTH-1:0] bid_o,
   output logic [1:0]          bresp_o,
   output logic                bvalid_o,
   input  logic                bready_i,
   input  logic [ID_WIDTH-1:0] arid_i,
   input  logic [31:0]         araddr_i,
   input  logic [3:0]          arlen_i,
   input  logic [2:0]          arsize_i,
   input  logic [1:0]          arburst_i,
   input  logic                arvalid_i,
   output logic                arready_o,
   output logic [ID_WIDTH-1:0] rid_o,
   output logic [31:0]         rdata_o,
   output logic [1:0]          rresp_o,
   output logic                rlast_o,
   output logic                rvalid_o,
   input  logic                rready_i,
   output logic                psel_o,
   output logic                penable_o,
   output logic                pwrite_o,
   output logic [31:0]         paddr_o,
   output logic [31:0]         pwdata_o,
   output logic [3:0]          pstrb_o,
   input  logic [31:0]         prdata_i,
   input  logic                pready_i,
   input  logic                pslverr_i
);

   localparam bit         TMO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [31:0]           addr_q, addr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [1:0]            burst_q, burst_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  rlast_q, rlast_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [7:0]            tmo_q, tmo_d;
   logic                  rd_prio_q, rd_prio_d;   // 1: read wins a tie

   logic                  idle_s;
   logic                  grant_rd_s;
   logic                  grant_wr_s;
   logic                  tmo_fire_s;
   logic                  last_beat_s;
   logic                  rd_ph_s;
   logic                  wr_ph_s;
   logic                  unused_s;

   // Size is ignored and wid is redundant with a single in-order transaction.
   assign unused_s = ^{wid_i, awsize_i, arsize_i};

   assign idle_s      = (state_q == ST_IDLE);
   assign grant_rd_s  = arvalid_i & (~awvalid_i | rd_prio_q);
   assign grant_wr_s  = awvalid_i & (~arvalid_i | ~rd_prio_q);
   assign arready_o   = idle_s & grant_rd_s;
   assign awready_o   = idle_s & grant_wr_s;
   assign last_beat_s = (cnt_q == 4'd0);
   // The counter is 0 in the first ACCESS cycle, so firing at TIMEOUT_CYC-1
   // leaves penable high for exactly TIMEOUT_CYC cycles.
   assign tmo_fire_s  = TMO_EN && (tmo_q == TMO_LAST);

   // APB and AXI response outputs are pure decodes of registered state.
   assign rd_ph_s   = (state_q == ST_RSETUP) || (state_q == ST_RACCESS);
   assign wr_ph_s   = (state_q == ST_WSETUP) || (state_q == ST_WACCESS);
   assign psel_o    = rd_ph_s | wr_ph_s;
   assign penable_o = (state_q == ST_RACCESS) || (state_q == ST_WACCESS);
   assign pwrite_o  = wr_ph_s;
   assign paddr_o   = psel_o ? {addr_q[31:2], 2'b00} : 32'd0;
   assign pwdata_o  = wr_ph_s ? wdata_q : 32'd0;
   assign pstrb_o   = wr_ph_s ? wstrb_q : 4'd0;
   assign wready_o  = (state_q == ST_WDATA);
   assign rvalid_o  = (state_q == ST_RDATA);
   assign rid_o     = rvalid_o ? id_q : '0;
   assign rdata_o   = rvalid_o ? rdata_q : 32'd0;
   assign rresp_o   = rvalid_o ? rresp_q : RESP_OKAY;
   assign rlast_o   = rvalid_o & rlast_q;
   assign bvalid_o  = (state_q == ST_BRESP);
   assign bid_o     = bvalid_o ? id_q : '0;
   assign bresp_o   = bvalid_o ? (err_q ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;

   // Next-state and datapath update for the transfer sequencer.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      burst_d   = burst_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      tmo_d     = tmo_q;
      rd_prio_d = rd_prio_q;
      case (state_q)
         ST_IDLE: begin
            if (arready_o) begin
               id_d      = arid_i;
               addr_d    = araddr_i;
               cnt_d     = arlen_i;
               burst_d   = arburst_i;
               err_d     = 1'b0;
               rd_prio_d = ~rd_prio_q;
               state_d   = ST_RSETUP;
            end else if (awready_o) begin
               id_d      = awid_i;
               addr_d    = awaddr_i;
               cnt_d     = awlen_i;
               burst_d   = awburst_i;
               err_d     = 1'b0;
               rd_prio_d = ~rd_prio_q;
               state_d   = ST_WDATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RSETUP: begin
            tmo_d   = 8'd0;
            state_d = ST_RACCESS;
         end
         ST_RACCESS: begin
            if (pready_i) begin
               rdata_d = prdata_i;
               rresp_d = pslverr_i ? RESP_SLVERR : RESP_OKAY;
               rlast_d = last_beat_s;
               state_d = ST_RDATA;
            end else if (tmo_fire_s) begin
               rdata_d = 32'd0;
               rresp_d = RESP_SLVERR;
               rlast_d = last_beat_s;
               state_d = ST_RDATA;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         ST_RDATA: begin
            if (rready_i) begin
               if (last_beat_s) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
                  addr_d  = next_addr(addr_q, burst_q);
                  state_d = ST_RSETUP;
               end
            end else begin
               state_d = ST_RDATA;
            end
         end
         ST_WDATA: begin
            if (wvalid_i) begin
               wdata_d = wdata_i;
               wstrb_d = wstrb_i;
               // A misplaced (or missing) wlast poisons the whole burst.
               err_d   = err_q | (wlast_i != last_beat_s);
               state_d = ST_WSETUP;
            end else begin
               state_d = ST_WDATA;
            end
         end
         ST_WSETUP: begin
            tmo_d   = 8'd0;
            state_d = ST_WACCESS;
         end
         ST_WACCESS: begin
            if (pready_i || tmo_fire_s) begin
               if (pready_i) begin
                  err_d = err_q | pslverr_i;
               end else begin
                  err_d = 1'b1;
               end
               if (last_beat_s) begin
                  state_d = ST_BRESP;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
                  addr_d  = next_addr(addr_q, burst_q);
                  state_d = ST_WDATA;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         ST_BRESP: begin
            if (bready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BRESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any burst in progress at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         addr_q    <= 32'd0;
         cnt_q     <= 4'd0;
         burst_q   <= 2'b00;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= 2'b00;
         rlast_q   <= 1'b0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         tmo_q     <= 8'd0;
         rd_prio_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         tmo_q     <= tmo_d;
         rd_prio_q <= rd_prio_d;
      end
   end

endmodule

// File: tb/tb_axi_apb_slave_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_apb_slave_bridge
// Self-checking bench: an APB completer model with random wait states and
// errors logs every transfer it sees; AXI-side expectations are derived from
// burst arithmetic, the completer's own choices and a round-robin model.
// -----------------------------------------------------------------------------
module tb_axi_apb_slave_bridge;
   import axi_apb_pkg::*;

   localparam int IDW = 4;
   localparam int TMO = 4;
   localparam int WAIT_MAX = 100;

   logic clk = 1'b0;
   logic rst_n;
   logic [IDW-1:0] awid_i, wid_i, arid_i, bid_o, rid_o;
   logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o, paddr_o, pwdata_o, prdata_i;
   logic [3:0]  awlen_i, arlen_i, wstrb_i, pstrb_o;
   logic [2:0]  awsize_i, arsize_i;
   logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
   logic awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
   logic arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
   logic psel_o, penable_o, pwrite_o, pready_i, pslverr_i;

   always #5 clk = ~clk;

   axi_apb_slave_bridge #(.ID_WIDTH(IDW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
      .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
      .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
      .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- APB completer model ----------------
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        err;
      logic [31:0] rdata;
   } apb_t;

   apb_t        apb_q[$];
   apb_t        ent;
   int          max_wait   = 2;
   int          err_mode   = 2;      // 0 never, 1 always, 2 random
   bit          hold_ready = 1'b0;
   int          wcnt       = 0;
   int          last_acc   = 0;      // ACCESS cycles of the latest transfer
   logic        cur_err;
   logic [31:0] cur_rdata;

   // Completer: log each SETUP, then answer after a random number of wait states.
   always @(negedge clk) begin
      if (psel_o && !penable_o) begin
         ent.addr  = paddr_o;
         ent.wr    = pwrite_o;
         ent.wdata = pwdata_o;
         ent.strb  = pstrb_o;
         ent.err   = (err_mode == 1) ? 1'b1 : ((err_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
         ent.rdata = $urandom();
         cur_err   = ent.err;
         cur_rdata = ent.rdata;
         apb_q.push_back(ent);
         wcnt      = $urandom_range(0, max_wait);
         last_acc  = 0;
         pready_i  = 1'b0; pslverr_i = 1'b0; prdata_i = 32'd0;
      end else if (psel_o && penable_o) begin
         last_acc++;
         if (!hold_ready && wcnt == 0) begin
            pready_i = 1'b1; pslverr_i = cur_err; prdata_i = cur_rdata;
         end else begin
            if (wcnt > 0) wcnt--;
            pready_i = 1'b0; pslverr_i = $urandom_range(0, 1); prdata_i = $urandom();
         end
      end else begin
         pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'd0;
      end
   end

   // ---------------- AXI side helpers ----------------
   bit          rd_prio_m;            // model: 1 when a tie goes to the read
   logic [31:0] wd_m[16];
   logic [3:0]  ws_m[16];

   function automatic bit get_sig(input int which);
      case (which)
         0: return arready_o;
         1: return awready_o;
         2: return rvalid_o;
         3: return wready_o;
         4: return bvalid_o;
         5: return psel_o && penable_o;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input string tag, output int t);
      t = 0;
      while (!get_sig(which) && t < WAIT_MAX) begin
         @(negedge clk); #1;
         t++;
      end
      check_val({tag, "_wait"}, (t < WAIT_MAX), 1);
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int k);
      logic [31:0] r;
      r = (b == BURST_FIXED) ? a : a + 32'(4 * k);
      r[1:0] = 2'b00;
      return r;
   endfunction

   task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] b);
      arid_i = id; araddr_i = a; arlen_i = len; arburst_i = b; arsize_i = 3'($urandom_range(0, 7)); arvalid_i = 1'b1;
   endtask

   task automatic issue_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] b);
      awid_i = id; awaddr_i = a; awlen_i = len; awburst_i = b; awsize_i = 3'($urandom_range(0, 7)); awvalid_i = 1'b1;
   endtask

   task automatic take_ar();
      int t;
      wait_for(0, "arready", t);
      rd_prio_m = ~rd_prio_m;
      @(negedge clk); arvalid_i = 1'b0; #1;
   endtask

   task automatic take_aw();
      int t;
      wait_for(1, "awready", t);
      rd_prio_m = ~rd_prio_m;
      @(negedge clk); awvalid_i = 1'b0; #1;
   endtask

   task automatic r_beats(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] b, input int rdelay, input bit tmo, input bit lat_chk);
      int t, d;
      apb_t e;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      for (int k = 0; k <= int'(len); k++) begin
         wait_for(2, "rvalid", t);
         // Handshake in cycle 0, RSETUP 1, RACCESS 2, rvalid in cycle 3.
         if (lat_chk && k == 0) check_val("rd_latency", t, 2);
         exp_d = 32'd0; exp_r = RESP_SLVERR;
         check_val("rd_apb_logged", apb_q.size() > 0, 1);
         if (apb_q.size() > 0) begin
            e = apb_q.pop_front();
            check_val("rd_paddr", e.addr, beat_addr(a, b, k));
            check_val("rd_pwrite_pwdata", {e.wr, e.wdata, e.strb}, 37'd0);
            exp_d = tmo ? 32'd0 : e.rdata;
            exp_r = (tmo || e.err) ? RESP_SLVERR : RESP_OKAY;
         end
         check_val("rdata_first", rdata_o, exp_d);
         d = (rdelay < 0) ? $urandom_range(0, 2) : rdelay;
         for (int i = 0; i < d; i++) begin @(negedge clk); #1; end
         check_val("rvalid_held", rvalid_o, 1);
         check_val("rid", rid_o, id);
         check_val("rdata", rdata_o, exp_d);
         check_val("rresp", rresp_o, exp_r);
         check_val("rlast", rlast_o, (k == int'(len)));
         rready_i = 1'b1;
         @(negedge clk); rready_i = 1'b0; #1;
      end
   endtask

   task automatic w_beats(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] b, input int bad_beat);
      int t, d;
      apb_t e;
      bit exp_err;
      exp_err = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         wait_for(3, "wready", t);
         d = $urandom_range(0, 2);
         for (int i = 0; i < d; i++) begin @(negedge clk); #1; end
         wid_i = id; wdata_i = wd_m[k]; wstrb_i = ws_m[k];
         wlast_i = (k == int'(len)) ^ (k == bad_beat);
         if (k == bad_beat) exp_err = 1'b1;
         wvalid_i = 1'b1;
         @(negedge clk); wvalid_i = 1'b0; wlast_i = 1'b0; #1;
      end
      wait_for(4, "bvalid", t);
      check_val("wr_apb_count", apb_q.size(), int'(len) + 1);
      for (int k = 0; k <= int'(len) && apb_q.size() > 0; k++) begin
         e = apb_q.pop_front();
         check_val("wr_paddr", e.addr, beat_addr(a, b, k));
         check_val("wr_pwrite", e.wr, 1);
         check_val("wr_pwdata", e.wdata, wd_m[k]);
         check_val("wr_pstrb", e.strb, ws_m[k]);
         if (e.err) exp_err = 1'b1;
      end
      d = $urandom_range(0, 2);
      for (int i = 0; i < d; i++) begin @(negedge clk); #1; end
      check_val("bid", bid_o, id);
      check_val("bresp", bresp_o, exp_err ? RESP_SLVERR : RESP_OKAY);
      bready_i = 1'b1;
      @(negedge clk); bready_i = 1'b0; #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ctrl"}, {awready_o, wready_o, bvalid_o, arready_o, rvalid_o, rlast_o,
                                 psel_o, penable_o, pwrite_o}, 0);
      check_val({tag, "_ids"}, {bid_o, bresp_o, rid_o, rresp_o}, 0);
      check_val({tag, "_rdata"}, rdata_o, 0);
      check_val({tag, "_paddr"}, paddr_o, 0);
      check_val({tag, "_pwdata"}, {pwdata_o, pstrb_o}, 0);
   endtask

   // Hard stop in case a wait loop is ever bypassed.
   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, bad;
      logic [3:0]  id, len;
      logic [31:0] a;
      logic [1:0]  b;

      rst_n = 1'b0;
      {awvalid_i, wvalid_i, wlast_i, bready_i, arvalid_i, rready_i} = '0;
      {awid_i, wid_i, arid_i, awaddr_i, araddr_i, wdata_i} = '0;
      {awlen_i, arlen_i, wstrb_i, awsize_i, arsize_i, awburst_i, arburst_i} = '0;
      rd_prio_m = 1'b1;
      #12;
      check_all_zero("reset");
      @(negedge clk); rst_n = 1'b1; #1;

      // Tie-break: first tie goes to read, the next tie (write still pending) to write.
      err_mode = 0; max_wait = 2;
      @(negedge clk);
      issue_ar(4'd1, 32'h300, 4'd0, BURST_INCR);
      issue_aw(4'd2, 32'h400, 4'd0, BURST_INCR);
      #1;
      check_val("arb1_arready", arready_o, 1);
      check_val("arb1_awready", awready_o, 0);
      take_ar();
      r_beats(4'd1, 32'h300, 4'd0, BURST_INCR, -1, 1'b0, 1'b0);
      issue_ar(4'd5, 32'h500, 4'd0, BURST_INCR);
      #1;
      check_val("arb2_arready", arready_o, 0);
      check_val("arb2_awready", awready_o, 1);
      wd_m[0] = 32'h1234_5678; ws_m[0] = 4'h3;
      take_aw();
      w_beats(4'd2, 32'h400, 4'd0, BURST_INCR, -1);
      take_ar();
      r_beats(4'd5, 32'h500, 4'd0, BURST_INCR, -1, 1'b0, 1'b0);

      // 4-beat INCR read with zero wait states, including minimum latency.
      max_wait = 0;
      @(negedge clk); issue_ar(4'd3, 32'h100, 4'd3, BURST_INCR); #1;
      take_ar();
      r_beats(4'd3, 32'h100, 4'd3, BURST_INCR, -1, 1'b0, 1'b1);
      max_wait = 2;

      // 2-beat FIXED write to one address.
      wd_m[0] = 32'hA5A5_A5A5; ws_m[0] = 4'hF;
      wd_m[1] = 32'h5A5A_5A5A; ws_m[1] = 4'hF;
      @(negedge clk); issue_aw(4'd6, 32'h200, 4'd1, BURST_FIXED); #1;
      take_aw();
      w_beats(4'd6, 32'h200, 4'd1, BURST_FIXED, -1);

      // Error on a single-beat write, then a clean read is OKAY again.
      err_mode = 1;
      wd_m[0] = 32'hDEAD_BEEF; ws_m[0] = 4'hC;
      @(negedge clk); issue_aw(4'd9, 32'h240, 4'd0, BURST_INCR); #1;
      take_aw();
      w_beats(4'd9, 32'h240, 4'd0, BURST_INCR, -1);
      err_mode = 0;
      @(negedge clk); issue_ar(4'd10, 32'h244, 4'd0, BURST_INCR); #1;
      take_ar();
      r_beats(4'd10, 32'h244, 4'd0, BURST_INCR, -1, 1'b0, 1'b0);

      // Timeout: no pready ever; R held 5 cycles with rready low.
      hold_ready = 1'b1;
      @(negedge clk); issue_ar(4'd11, 32'h700, 4'd0, BURST_INCR); #1;
      take_ar();
      r_beats(4'd11, 32'h700, 4'd0, BURST_INCR, 5, 1'b1, 1'b0);
      check_val("tmo_access_cycles", last_acc, TMO);
      hold_ready = 1'b0;

      // Reset in the ACCESS phase of beat 2 aborts the burst.
      max_wait = 0;
      @(negedge clk); issue_ar(4'd7, 32'h600, 4'd3, BURST_INCR); #1;
      take_ar();
      wait_for(2, "abort_rvalid", t);
      hold_ready = 1'b1;
      rready_i = 1'b1;
      @(negedge clk); rready_i = 1'b0; #1;
      wait_for(5, "abort_access", t);
      rst_n = 1'b0; #1;
      check_val("abort_psel_penable", {psel_o, penable_o}, 0);
      check_val("abort_rvalid", rvalid_o, 0);
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("abort_hold");
      @(negedge clk); rst_n = 1'b1; hold_ready = 1'b0; #1;
      apb_q.delete();
      rd_prio_m = 1'b1;
      max_wait = 2;
      @(negedge clk); issue_ar(4'd8, 32'h800, 4'd1, BURST_INCR); #1;
      check_val("post_reset_arready", arready_o, 1);
      take_ar();
      r_beats(4'd8, 32'h800, 4'd1, BURST_INCR, -1, 1'b0, 1'b0);

      // Random traffic with random wait states, errors and wlast faults.
      err_mode = 2;
      for (int n = 0; n < 30; n++) begin
         id  = 4'($urandom_range(0, 15));
         a   = $urandom();
         len = 4'($urandom_range(0, 7));
         b   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clk); issue_ar(id, a, len, b); #1;
            take_ar();
            r_beats(id, a, len, b, -1, 1'b0, 1'b0);
         end else begin
            for (int k = 0; k < 16; k++) begin
               wd_m[k] = $urandom();
               ws_m[k] = 4'($urandom_range(0, 15));
            end
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            @(negedge clk); issue_aw(id, a, len, b); #1;
            take_aw();
            w_beats(id, a, len, b, bad);
         end
      end

      // Simultaneous random pair: the tie goes where the round-robin model says.
      @(negedge clk);
      issue_ar(4'd12, 32'h900, 4'd0, BURST_INCR);
      issue_aw(4'd13, 32'hA00, 4'd0, BURST_INCR);
      #1;
      check_val("arb_model_arready", arready_o, rd_prio_m);
      check_val("arb_model_awready", awready_o, !rd_prio_m);
      wd_m[0] = 32'h0BAD_F00D; ws_m[0] = 4'h9;
      if (rd_prio_m) begin
         take_ar(); r_beats(4'd12, 32'h900, 4'd0, BURST_INCR, -1, 1'b0, 1'b0);
         take_aw(); w_beats(4'd13, 32'hA00, 4'd0, BURST_INCR, -1);
      end else begin
         take_aw(); w_beats(4'd13, 32'hA00, 4'd0, BURST_INCR, -1);
         take_ar(); r_beats(4'd12, 32'h900, 4'd0, BURST_INCR, -1, 1'b0, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
